wide_add_sequencer: RTL and testbench
=====================================

Name: wide_add_sequencer

Overview:
- Multi-cycle controller that adds two wide operands by time-sharing one narrow carry-in/carry-out slice adder, one slice per clock, LSB slice first.
- Carry is registered between slices.
- Sits between a requester (valid/ready in) and a consumer (valid/ready out). Lets the 8-bit ripple-carry datapath serve 16/32/64/128-bit additions without replicating it.

Parameters:
- SLICE_BITS, 8: width of the shared slice adder.
- NUM_SLICES, 4: slices per operation, minimum 1.
- TOTAL_BITS, SLICE_BITS*NUM_SLICES: operand and result width (derived, not overridden).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- in_valid  in  1  requester presents operands.
- in_ready  out  1  sequencer can accept operands.
- A  in  TOTAL_BITS  operand A.
- B  in  TOTAL_BITS  operand B.
- out_valid  out  1  result and carryout are valid.
- out_ready  in  1  consumer takes the result.
- result  out  TOTAL_BITS  sum modulo 2^TOTAL_BITS.
- carryout  out  1  carry out of the MSB slice.

Behaviour:
- Reset (async assert, sync deassert by clk):
  - State is IDLE, in_ready=1, out_valid=0, result=0, carryout=0.
  - Slice index=0, carry register=0, operand registers=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch A and B, index=0, carry=0, go to CALC.
  - CALC: in_ready=0, out_valid=0. Each cycle, slice[index] = A_slice + B_slice + carry. Write the sum into result[index*SLICE_BITS +: SLICE_BITS] and carry <= slice cout. If index==NUM_SLICES-1, go to HOLD and set carryout <= slice cout; otherwise index++.
  - HOLD: out_valid=1, in_ready=0. result and carryout held stable. On out_ready, go to IDLE.
- Latency: out_valid rises exactly NUM_SLICES clock edges after the accepting edge. Throughput is one operation per NUM_SLICES+2 cycles minimum; input and output phases do not overlap.
- Operand isolation: A, B and in_valid are ignored outside IDLE. Changes during CALC or HOLD do not affect the result.
- result:
  - Updates only during CALC. Upper slices retain their previous values until overwritten.
  - Consumers sample result only while out_valid=1.
- NUM_SLICES=1: one CALC cycle. Index register width is max(1, clog2(NUM_SLICES)).
- Wrap-around: the sum is truncated to TOTAL_BITS and the overflow bit appears only on carryout.
- Reset mid-operation: any state goes immediately to IDLE. The partial result is discarded and nothing is emitted.
- Simultaneous in_valid and out_ready in HOLD: the request is not accepted that cycle. It is accepted in the following IDLE cycle.

Optional Feature:
- WIDE_ADD_SUB_EN defined:
  - Adds input port sub (1 bit), latched at accept.
  - sub=1 computes A-B: B is inverted per slice and the initial carry is 1. carryout=1 means no borrow.
- Macro undefined: sub port absent; addition only, initial carry 0.

Decomposition:
- Package adder_seq_pkg holds:
  - the state enum (IDLE, CALC, HOLD), 2-bit encoding;
  - default SLICE_BITS/NUM_SLICES constants;
  - the index-width function.
- One sub-module: rca_slice, a combinational SLICE_BITS ripple-carry adder with cin/cout, built from full adders and instantiated once.

Test Plan:
1. A=0x00000000, B=0x00000000 -> result=0x00000000, carryout=0, out_valid exactly 4 edges after accept.
2. A=0x000000FF, B=0x00000001 -> result=0x00000100, carryout=0 (inter-slice carry propagates).
3. A=0xFFFFFFFF, B=0x00000001 -> result=0x00000000, carryout=1 (carry ripples through all 4 slices).
4. After test 3, hold out_ready=0 for 3 cycles; change A/B; pulse in_valid -> result/out_valid stable, in_ready=0. Then out_ready=1 -> IDLE next cycle with in_ready=1.
5. Start A=0x12345678, B=0x11111111 and assert reset after 2 CALC cycles -> out_valid=0, result=0, in_ready=1 after release. Then A=0x000000D5, B=0x00000064 -> result=0x00000139, carryout=0.
6. WIDE_ADD_SUB_EN: sub=1, A=5, B=7 -> 0xFFFFFFFE, carryout=0; A=7, B=5 -> 0x00000002, carryout=1. Also rerun tests 1-5 with NUM_SLICES=1, 2, 16.

Source files
------------

// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the wide_add_sequencer slice.
// Holds the controller state encoding, default slice geometry and the index-width helper.
// No logic lives here; everything is compile-time.
package adder_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int DEF_SLICE_BITS = 8;
  localparam int DEF_NUM_SLICES = 4;

  // Slice index width; a single-slice build still needs a 1-bit index register.
  function automatic int idx_width(input int num_slices);
    return (num_slices <= 1) ? 1 : $clog2(num_slices);
  endfunction

endpackage

// File: rtl/rca_slice.sv
// Combinational W-bit ripple-carry adder with carry in and carry out.
// Latency: zero cycles, purely combinational.
// Backpressure: none; outputs follow inputs.
module rca_slice
  import adder_seq_pkg::*;
#(
  parameter int W = DEF_SLICE_BITS
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] c;

  assign c[0] = cin;

  // One full adder per bit, carry chained LSB to MSB.
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[W];

endmodule

// File: rtl/wide_add_sequencer.sv
// Wide adder that time-shares one SLICE_BITS ripple-carry slice, LSB slice first (WIDE_ADD_SUB_EN adds A-B mode).
// Latency: out_valid rises NUM_SLICES clock edges after the accepting edge.
// Backpressure: result held in HOLD until out_ready; no new request accepted until back in IDLE.
module wide_add_sequencer
  import adder_seq_pkg::*;
#(
  parameter  int SLICE_BITS = DEF_SLICE_BITS,
  parameter  int NUM_SLICES = DEF_NUM_SLICES,
  localparam int TOTAL_BITS = SLICE_BITS * NUM_SLICES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [TOTAL_BITS-1:0] A,
  input  logic [TOTAL_BITS-1:0] B,
`ifdef WIDE_ADD_SUB_EN
  input  logic                  sub,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TOTAL_BITS-1:0] result,
  output logic                  carryout
);

  localparam int IW = idx_width(NUM_SLICES);

  state_t                  state_q;
  state_t                  state_d;
  logic [IW-1:0]           idx_q;
  logic                    carry_q;
  logic [TOTAL_BITS-1:0]   a_q;
  logic [TOTAL_BITS-1:0]   b_q;
`ifdef WIDE_ADD_SUB_EN
  logic                    sub_q;
`endif

  logic [SLICE_BITS-1:0]   a_sl;
  logic [SLICE_BITS-1:0]   b_sl;
  logic [SLICE_BITS-1:0]   b_op;
  logic [SLICE_BITS-1:0]   sum_sl;
  logic                    cout_sl;
  logic                    last_slice;

  assign last_slice = (idx_q == IW'(NUM_SLICES - 1));

  // Pick the operand slice addressed by the current index (B inverted when subtracting).
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int s = 0; s < NUM_SLICES; s++) begin
      if (idx_q == IW'(s)) begin
        a_sl = a_q[s*SLICE_BITS +: SLICE_BITS];
        b_sl = b_q[s*SLICE_BITS +: SLICE_BITS];
      end
    end
`ifdef WIDE_ADD_SUB_EN
    b_op = sub_q ? ~b_sl : b_sl;
`else
    b_op = b_sl;
`endif
  end

  rca_slice #(
    .W(SLICE_BITS)
  ) u_slice (
    .a   (a_sl),
    .b   (b_op),
    .cin (carry_q),
    .sum (sum_sl),
    .cout(cout_sl)
  );

  // Controller state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs; input and output phases never overlap.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = CALC;
        end
      end
      CALC: begin
        if (last_slice) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand capture at accept, then one slice per cycle into result with the carry registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result   <= '0;
      carryout <= 1'b0;
`ifdef WIDE_ADD_SUB_EN
      sub_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= A;
            b_q   <= B;
            idx_q <= '0;
`ifdef WIDE_ADD_SUB_EN
            sub_q   <= sub;
            carry_q <= sub;
`else
            carry_q <= 1'b0;
`endif
          end
        end
        CALC: begin
          for (int s = 0; s < NUM_SLICES; s++) begin
            if (idx_q == IW'(s)) begin
              result[s*SLICE_BITS +: SLICE_BITS] <= sum_sl;
            end
          end
          carry_q <= cout_sl;
          if (last_slice) begin
            carryout <= cout_sl;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer: directed cases plus randomized traffic.
// Expected sums come from plain wide arithmetic; a monitor compares at each new out_valid.
// out_ready is driven by a separate process (always-ready, random, or held low).
module tb_wide_add_sequencer;

  parameter int NS = 4;
  localparam int SB = 8;
  localparam int TW = SB * NS;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] A;
  logic [TW-1:0] B;
`ifdef WIDE_ADD_SUB_EN
  logic          sub;
`endif
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] result;
  logic          carryout;

  wide_add_sequencer #(
    .SLICE_BITS(SB),
    .NUM_SLICES(NS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
`ifdef WIDE_ADD_SUB_EN
    .sub      (sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .carryout (carryout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int rdy_mode = 0;

  typedef struct {
    logic [TW:0] exp;
    int          acc;
  } item_t;

  item_t sb_q[$];

  task automatic check(input string name, input logic [TW:0] act, input logic [TW:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [TW-1:0] rnd();
    logic [TW-1:0] v;
    v = '0;
    for (int i = 0; i < TW; i += 32) begin
      v = (v << 32) | TW'($urandom);
    end
    return v;
  endfunction

  // Consumer side: 0 = always ready, 1 = random, otherwise stalled.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compare on each rising out_valid, check stability while held.
  logic        prev_ov = 1'b0;
  logic [TW:0] held = '0;
  item_t       mon_it;
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid && !prev_ov) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got %h with no request outstanding", {carryout, result});
        end else begin
          mon_it = sb_q[0];
          check("latency", (TW+1)'(cyc - mon_it.acc), (TW+1)'(NS));
          check("sum", {carryout, result}, mon_it.exp);
        end
        held = {carryout, result};
      end else if (out_valid) begin
        check("hold_stable", {carryout, result}, held);
      end
      if (out_valid && out_ready && sb_q.size() > 0) begin
        void'(sb_q.pop_front());
      end
      prev_ov = out_valid;
    end
  end

  task automatic do_op(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic s);
    item_t it;
    int    w;
    @(posedge clk);
    #1;
    A = a;
    B = b;
`ifdef WIDE_ADD_SUB_EN
    sub = s;
`endif
    in_valid = 1'b1;
    w = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      w++;
      if (w > 500) begin
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", w);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    if (s) it.exp = {1'b0, a} + {1'b0, ~b} + (TW+1)'(1);
    else   it.exp = {1'b0, a} + {1'b0, b};
    it.acc = cyc;
    sb_q.push_back(it);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (sb_q.size() > 0 && w < 3000) begin
      @(posedge clk);
      w++;
    end
    if (sb_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int k;
    logic s;
    reset    = 1'b1;
    in_valid = 1'b0;
    A        = '0;
    B        = '0;
`ifdef WIDE_ADD_SUB_EN
    sub      = 1'b0;
`endif
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", (TW+1)'(in_ready), (TW+1)'(1));
    check("rst_out_valid", (TW+1)'(out_valid), '0);
    check("rst_result", (TW+1)'(result), '0);
    check("rst_carryout", (TW+1)'(carryout), '0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Zero, inter-slice carry, full ripple.
    do_op('0, '0, 1'b0);
    wait_drain();
    do_op(TW'(32'h000000FF), TW'(32'h00000001), 1'b0);
    wait_drain();

    // Full ripple with the consumer stalled; inputs wiggle while holding.
    rdy_mode = 2;
    do_op('1, TW'(32'h00000001), 1'b0);
    w = 0;
    while (!out_valid && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("hold_reached", (TW+1)'(out_valid), (TW+1)'(1));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      A = rnd();
      B = rnd();
      in_valid = 1'b1;
      @(negedge clk);
      check("hold_in_ready", (TW+1)'(in_ready), '0);
      check("hold_out_valid", (TW+1)'(out_valid), (TW+1)'(1));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rdy_mode = 0;
    @(negedge clk);
    @(negedge clk);
    check("release_in_ready", (TW+1)'(in_ready), (TW+1)'(1));
    check("release_out_valid", (TW+1)'(out_valid), '0);
    wait_drain();

    // Reset in the middle of CALC discards the operation.
    do_op(TW'(32'h12345678), TW'(32'h11111111), 1'b0);
    k = (NS > 2) ? 2 : NS - 1;
    repeat (k) @(posedge clk);
    #1;
    reset = 1'b0;
    void'(sb_q.pop_back());
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", (TW+1)'(out_valid), '0);
    check("midrst_result", (TW+1)'(result), '0);
    check("midrst_in_ready", (TW+1)'(in_ready), (TW+1)'(1));
    do_op(TW'(32'h000000D5), TW'(32'h00000064), 1'b0);
    wait_drain();

`ifdef WIDE_ADD_SUB_EN
    do_op(TW'(5), TW'(7), 1'b1);
    do_op(TW'(7), TW'(5), 1'b1);
    wait_drain();
`endif

    // Randomized traffic with a random consumer.
    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
`ifdef WIDE_ADD_SUB_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      if ($urandom_range(0, 3) == 0) do_op('1, rnd(), s);
      else                           do_op(rnd(), rnd(), s);
    end
    wait_drain();
    rdy_mode = 0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
